// File: rtl/gpu_pkg.sv
// Shared types and defaults for the GPU lane scheduler slice.
package gpu_pkg;

    localparam int NUM_LANES_DEF = 4;
    localparam int DATA_W_DEF    = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        WRITE
    } sched_state_e;

    typedef logic [$clog2(NUM_LANES_DEF)-1:0] lane_idx_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin select: first requesting lane at or after ptr, wrapping.
module rr_arbiter
    import gpu_pkg::*;
#(
    parameter  int NUM_LANES = NUM_LANES_DEF,
    localparam int IDX_W     = $clog2(NUM_LANES)
) (
    input  logic [NUM_LANES-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic [NUM_LANES-1:0] grant,
    output logic [IDX_W-1:0]     idx,
    output logic                 any_req
);

    always_comb begin
        logic [IDX_W-1:0] cand;
        // NOTE: every output gets a default before the loop, so no path leaves one unassigned (no latch).
        grant   = '0;
        idx     = '0;
        any_req = 1'b0;
        cand    = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            cand = ptr + IDX_W'(i);  // NUM_LANES is a power of 2, so this wraps naturally
            if (!any_req && req[cand]) begin
                any_req     = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/gpu_lane_scheduler.sv
// Round-robin sharing of gpu_core between lanes, with vsync-swapped front/back result buffers.
// Optional WAIT-state timeout abort enabled by defining GPU_SCHED_TIMEOUT_EN.
module gpu_lane_scheduler
    import gpu_pkg::*;
#(
    parameter int NUM_LANES = NUM_LANES_DEF,
    parameter int DATA_W    = DATA_W_DEF
`ifdef GPU_SCHED_TIMEOUT_EN
    ,
    parameter int TIMEOUT   = 63
`endif
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          vsync,
    input  logic [NUM_LANES-1:0]          lane_req,
    input  logic [NUM_LANES*DATA_W-1:0]   lane_arg,
    input  logic                          core_ready,
    input  logic                          core_done,
    input  logic [DATA_W-1:0]             core_result,
    output logic                          core_start,
    output logic [$clog2(NUM_LANES)-1:0]  core_lane,
    output logic [DATA_W-1:0]             core_arg,
    output logic [NUM_LANES-1:0]          lane_grant,
    output logic [NUM_LANES*DATA_W-1:0]   display_data,
    output logic                          frame_swap,
`ifdef GPU_SCHED_TIMEOUT_EN
    output logic                          timeout_err,
`endif
    output logic                          busy
);

    localparam int IDX_W = $clog2(NUM_LANES);

    sched_state_e                state, state_nxt;
    logic [IDX_W-1:0]            rr_ptr;
    logic [IDX_W-1:0]            cur_lane;
    logic [DATA_W-1:0]           cur_arg;
    logic [DATA_W-1:0]           result_q;
    logic [NUM_LANES-1:0]        arb_grant;
    logic [IDX_W-1:0]            arb_idx;
    logic                        arb_any;
    logic [NUM_LANES*DATA_W-1:0] back_buf;
    logic [NUM_LANES*DATA_W-1:0] front_buf;
    logic                        vsync_prev;
    logic                        swap;

`ifdef GPU_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt;
    logic             timed_out;

    // A done pulse on the final WAIT cycle takes priority over the abort.
    assign timed_out = (state == WAIT) && !core_done && (wait_cnt == CNT_W'(TIMEOUT - 1));
`endif

    rr_arbiter #(.NUM_LANES(NUM_LANES)) u_arb (
        .req     (lane_req),
        .ptr     (rr_ptr),
        .grant   (arb_grant),
        .idx     (arb_idx),
        .any_req (arb_any)
    );

    assign swap         = !rst && vsync && !vsync_prev;
    assign core_lane    = cur_lane;
    assign core_arg     = cur_arg;
    assign display_data = front_buf;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (arb_any) state_nxt = ISSUE;
            ISSUE: if (core_ready) state_nxt = WAIT;
            WAIT: begin
                if (core_done) begin
                    state_nxt = WRITE;
                end
`ifdef GPU_SCHED_TIMEOUT_EN
                else if (timed_out) begin
                    state_nxt = IDLE;
                end
`endif
            end
            WRITE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are forced low while rst is held, before the state register has cleared.
    always_comb begin
        lane_grant = '0;
        core_start = 1'b0;
        busy       = 1'b0;
        frame_swap = swap;
`ifdef GPU_SCHED_TIMEOUT_EN
        timeout_err = 1'b0;
`endif
        if (!rst) begin
            busy       = (state != IDLE);
            core_start = (state == ISSUE) && core_ready;
            if (state == IDLE) begin
                lane_grant = arb_grant;
            end
`ifdef GPU_SCHED_TIMEOUT_EN
            timeout_err = timed_out;
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr   <= '0;
            cur_lane <= '0;
            cur_arg  <= '0;
            result_q <= '0;
`ifdef GPU_SCHED_TIMEOUT_EN
            wait_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        cur_lane <= arb_idx;
                        cur_arg  <= lane_arg[int'(arb_idx)*DATA_W +: DATA_W];
                    end
                end
                WAIT: begin
                    if (core_done) begin
                        result_q <= core_result;
                    end
`ifdef GPU_SCHED_TIMEOUT_EN
                    else if (timed_out) begin
                        rr_ptr <= cur_lane + IDX_W'(1);
                    end
`endif
                end
                WRITE:   rr_ptr <= cur_lane + IDX_W'(1);
                default: ;
            endcase
`ifdef GPU_SCHED_TIMEOUT_EN
            wait_cnt <= (state == WAIT) ? wait_cnt + CNT_W'(1) : '0;
`endif
        end
    end

    // NOTE: the buffers are flop arrays that must read as zero after reset, so they are reset explicitly.
    always_ff @(posedge clk) begin
        if (rst) begin
            back_buf   <= '0;
            front_buf  <= '0;
            vsync_prev <= 1'b0;
        end else begin
            vsync_prev <= vsync;
            // Same-edge swap and write: the swap copies the back buffer as it was before this write.
            if (swap) begin
                front_buf <= back_buf;
            end
            if (state == WRITE) begin
                back_buf[int'(cur_lane)*DATA_W +: DATA_W] <= result_q;
            end
`ifdef GPU_SCHED_TIMEOUT_EN
            else if (timed_out) begin
                back_buf[int'(cur_lane)*DATA_W +: DATA_W] <= '1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_gpu_lane_scheduler.sv
// Self-checking bench for gpu_lane_scheduler: directed scenarios plus randomized traffic against a job-level model.
module tb_gpu_lane_scheduler;
    import gpu_pkg::*;

    localparam int NL = NUM_LANES_DEF;
    localparam int DW = DATA_W_DEF;
`ifdef GPU_SCHED_TIMEOUT_EN
    localparam int TMO = 63;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 vsync;
    logic [NL-1:0]        lane_req;
    logic [NL*DW-1:0]     lane_arg;
    logic                 core_ready;
    logic                 core_done;
    logic [DW-1:0]        core_result;
    logic                 core_start;
    logic [$clog2(NL)-1:0] core_lane;
    logic [DW-1:0]        core_arg;
    logic [NL-1:0]        lane_grant;
    logic [NL*DW-1:0]     display_data;
    logic                 frame_swap;
    logic                 busy;
`ifdef GPU_SCHED_TIMEOUT_EN
    logic                 timeout_err;
`endif

    gpu_lane_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .vsync        (vsync),
        .lane_req     (lane_req),
        .lane_arg     (lane_arg),
        .core_ready   (core_ready),
        .core_done    (core_done),
        .core_result  (core_result),
        .core_start   (core_start),
        .core_lane    (core_lane),
        .core_arg     (core_arg),
        .lane_grant   (lane_grant),
        .display_data (display_data),
        .frame_swap   (frame_swap),
`ifdef GPU_SCHED_TIMEOUT_EN
        .timeout_err  (timeout_err),
`endif
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Job-level reference: where the single outstanding job is in its life, plus the two frame buffers.
    typedef enum int {J_NONE, J_GRANTED, J_RUNNING, J_FINISHED} job_e;

    job_e          job;
    int            ptr_m, lane_m, run_cnt, delay_m, cyc;
    logic [DW-1:0] arg_m, res_m;
    logic [DW-1:0] back_m  [NL];
    logic [DW-1:0] front_m [NL];
    logic          vs_prev_m;

    int      ready_pct  = 100;
    int      done_delay = 1;
    bit      rand_delay = 0;
    bit      auto_drop  = 0;
    bit      stray_done = 0;
    logic [NL-1:0] last_grant = '0;
    int      g_lane[$];
    int      g_cyc[$];
    int      start_cyc = 0, to_cyc = 0, to_count = 0;

    function automatic logic [NL*DW-1:0] packed_front();
        logic [NL*DW-1:0] r;
        for (int i = 0; i < NL; i++) r[i*DW +: DW] = front_m[i];
        return r;
    endfunction

    function automatic int pick(input logic [NL-1:0] req);
        for (int i = 0; i < NL; i++) begin
            if (req[(ptr_m + i) % NL]) return (ptr_m + i) % NL;
        end
        return -1;
    endfunction

    task automatic model_reset();
        job = J_NONE; ptr_m = 0; lane_m = 0; arg_m = '0; res_m = '0;
        run_cnt = 0; delay_m = 1; vs_prev_m = 1'b0;
        for (int i = 0; i < NL; i++) begin
            back_m[i]  = '0;
            front_m[i] = '0;
        end
    endtask

    // One clock cycle: drive core inputs, let logic settle, compare, advance the model, wait out the edge.
    task automatic tick();
        logic [NL-1:0] exp_g;
        int            gl;
        bit            sw, to;
        if (auto_drop) lane_req = lane_req & ~last_grant;
        core_done   = 1'b0;
        core_result = '0;
        if (!rst && job == J_RUNNING && run_cnt + 1 >= delay_m) begin
            core_done   = 1'b1;
            core_result = arg_m + 8'd1;
        end
        if (stray_done) begin
            core_done   = 1'b1;
            core_result = 8'hAA;
        end
        core_ready = (int'($urandom_range(99)) < ready_pct);
        #1;
        last_grant = lane_grant;
        if (rst) begin
            check("rst_grant", lane_grant, '0);
            check("rst_start", core_start, 0);
            check("rst_busy", busy, 0);
            check("rst_swap", frame_swap, 0);
            model_reset();
        end else begin
            gl    = (job == J_NONE) ? pick(lane_req) : -1;
            exp_g = (gl >= 0) ? (NL'(1) << gl) : '0;
            sw    = vsync && !vs_prev_m;
            to    = 1'b0;
`ifdef GPU_SCHED_TIMEOUT_EN
            to = (job == J_RUNNING) && !core_done && (run_cnt + 1 == TMO);
            check("timeout_err", timeout_err, to);
            if (timeout_err) begin
                to_cyc = cyc;
                to_count++;
            end
`endif
            check("grant", lane_grant, exp_g);
            check("busy", busy, job != J_NONE);
            check("core_start", core_start, (job == J_GRANTED) && core_ready);
            check("frame_swap", frame_swap, sw);
            check("display", display_data, packed_front());
            check("core_lane", core_lane, lane_m);
            check("core_arg", core_arg, arg_m);
            for (int i = 0; i < NL; i++) begin
                if (lane_grant[i]) begin
                    g_lane.push_back(i);
                    g_cyc.push_back(cyc);
                end
            end
            if (core_start) start_cyc = cyc;

            if (sw) for (int i = 0; i < NL; i++) front_m[i] = back_m[i];
            case (job)
                J_FINISHED: begin
                    back_m[lane_m] = res_m;
                    ptr_m = (lane_m + 1) % NL;
                    job   = J_NONE;
                end
                J_RUNNING: begin
                    if (core_done) begin
                        res_m = core_result;
                        job   = J_FINISHED;
                    end else if (to) begin
                        back_m[lane_m] = '1;
                        ptr_m = (lane_m + 1) % NL;
                        job   = J_NONE;
                    end else begin
                        run_cnt++;
                    end
                end
                J_GRANTED: begin
                    if (core_ready) begin
                        job     = J_RUNNING;
                        run_cnt = 0;
                    end
                end
                default: begin
                    if (gl >= 0) begin
                        job     = J_GRANTED;
                        lane_m  = gl;
                        arg_m   = lane_arg[gl*DW +: DW];
                        delay_m = rand_delay ? int'($urandom_range(5, 1)) : done_delay;
                    end
                end
            endcase
            vs_prev_m = vsync;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && job != J_NONE; k++) tick();
        check("drain_idle", job == J_NONE, 1);
    endtask

    task automatic vsync_pulse();
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        tick();
    endtask

    initial begin
        cyc = 0;
        model_reset();
        rst = 1'b1; vsync = 1'b0; lane_req = '0; lane_arg = '0;
        core_ready = 1'b0; core_done = 1'b0; core_result = '0;
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;
        check("reset_display", display_data, '0);
        check("reset_core_lane", core_lane, 0);
        check("reset_core_arg", core_arg, 0);
        check("reset_busy", busy, 0);

        // All four lanes at once: lane order, then results visible after one vsync.
        lane_arg   = {8'd40, 8'd30, 8'd20, 8'd10};
        done_delay = 3;
        auto_drop  = 1;
        lane_req   = 4'b1111;
        g_lane.delete(); g_cyc.delete();
        for (int k = 0; k < 80 && !(g_lane.size() == 4 && job == J_NONE); k++) tick();
        check("t1_grant_count", g_lane.size(), 4);
        for (int i = 0; i < 4 && i < g_lane.size(); i++) check($sformatf("t1_order%0d", i), g_lane[i], i);
        vsync_pulse();
        check("t1_display", display_data, {8'd41, 8'd31, 8'd21, 8'd11});

        // Lane 2 alone, fast core: back-to-back grants four cycles apart.
        auto_drop  = 0;
        done_delay = 1;
        lane_req   = 4'b0100;
        g_lane.delete(); g_cyc.delete();
        repeat (30) tick();
        lane_req = '0;
        drain();
        check("t2_grant_count", g_lane.size() >= 6, 1);
        for (int i = 0; i < g_lane.size(); i++) begin
            check("t2_lane", g_lane[i], 2);
            if (i > 0) check("t2_spacing", g_cyc[i] - g_cyc[i-1], 4);
        end

        // Core not ready for ten cycles while holding a job.
        ready_pct = 0;
        auto_drop = 1;
        lane_req  = 4'b0001;
        g_lane.delete();
        for (int k = 0; k < 10 && g_lane.size() == 0; k++) tick();
        check("t3_granted", g_lane.size(), 1);
        repeat (10) begin
            tick();
            check("t3_start_low", core_start, 0);
            check("t3_busy_high", busy, 1);
        end
        ready_pct  = 100;
        core_ready = 1'b1;
        #1;
        check("t3_start_pulse", core_start, 1);
        tick();
        drain();

        // vsync rise coinciding with the write of lane 1.
        lane_arg[15:8] = 8'h54;
        done_delay     = 2;
        lane_req       = 4'b0010;
        for (int k = 0; k < 40 && job != J_FINISHED; k++) tick();
        check("t4_reached_write", job == J_FINISHED, 1);
        vsync_pulse();
        check("t4_front_old", display_data[15:8], 8'd21);
        vsync_pulse();
        check("t4_front_new", display_data[15:8], 8'h55);

        // Reset in the middle of a job, then a stray done.
        done_delay = 1000;
        lane_req   = 4'b1000;
        for (int k = 0; k < 20 && job != J_RUNNING; k++) tick();
        check("t5_reached_wait", job == J_RUNNING, 1);
        tick();
        rst = 1'b1;
        tick();
        rst        = 1'b0;
        stray_done = 1;
        tick();
        stray_done = 0;
        repeat (3) tick();
        check("t5_busy", busy, 0);
        vsync_pulse();
        check("t5_display", display_data, '0);

`ifdef GPU_SCHED_TIMEOUT_EN
        // Withheld done aborts on the 63rd WAIT cycle; a done on that very cycle still wins.
        lane_req = 4'b0001;
        to_count = 0;
        for (int k = 0; k < 120 && to_count == 0; k++) tick();
        check("t6_timeout_seen", to_count, 1);
        check("t6_timeout_cycle", to_cyc - start_cyc, TMO);
        vsync_pulse();
        check("t6_all_ones", display_data[7:0], 8'hFF);
        done_delay = TMO;
        lane_req   = 4'b0001;
        to_count   = 0;
        tick();
        drain();
        check("t6_no_timeout", to_count, 0);
        vsync_pulse();
        check("t6_done_wins", display_data[7:0], 8'd11);
`endif

        // Randomized traffic: sporadic requests, changing args, stalls, vsync and rare resets.
        rand_delay = 1;
        ready_pct  = 70;
        repeat (2000) begin
            lane_req = lane_req | (NL'($urandom) & NL'($urandom));
            lane_arg = $urandom;
            if ($urandom_range(19) == 0) vsync = ~vsync;
            rst = ($urandom_range(399) == 0);
            tick();
        end
        rst       = 1'b0;
        lane_req  = '0;
        ready_pct = 100;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gpu_lane_scheduler.md
Name: gpu_lane_scheduler

Overview:
Round-robin scheduler that shares the single gpu_core compute datapath between NUM_LANES lane requesters. It issues one job at a time to the core and collects each result into a back buffer. On each vsync rising edge it copies the back buffer to a front buffer, so the VGA bar renderer always reads frame-stable lane values. The block sits between the top-level lane/button logic and gpu_core, in the 25 MHz pixel clock domain.

Parameters:
NUM_LANES, 4, number of requesting lanes (power of 2, 2..8)
DATA_W, 8, width of job argument and of each lane result
TIMEOUT, 63, WAIT-state cycles before a job is aborted (used only with the optional feature)

Ports:
clk  in  1  pixel clock (25 MHz domain)
rst  in  1  synchronous active-high reset
vsync  in  1  raw vsync from vga_controller; edge-detected internally
lane_req  in  NUM_LANES  per-lane job request, level-held until granted
lane_arg  in  NUM_LANES*DATA_W  per-lane job argument; lane i occupies bits [i*DATA_W +: DATA_W]
core_ready  in  1  core can accept a job
core_done  in  1  one-cycle pulse, result valid
core_result  in  DATA_W  job result
core_start  out  1  one-cycle job launch pulse
core_lane  out  $clog2(NUM_LANES)  lane index of the current job
core_arg  out  DATA_W  argument of the current job, held stable from ISSUE to done
lane_grant  out  NUM_LANES  one-hot, one-cycle pulse when a lane's request is accepted
display_data  out  NUM_LANES*DATA_W  front buffer, same lane packing as lane_arg
frame_swap  out  1  one-cycle pulse on the cycle the front buffer updates
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: FSM goes to IDLE; rr_ptr=0; all outputs 0; front and back buffers 0; vsync_prev=0.
- Reset asserted mid-job abandons the job. A late core_done arriving after reset is ignored in IDLE.
- States:
  - IDLE: if any lane_req is set, select the first requesting lane at or after rr_ptr (wrapping modulo NUM_LANES). Latch its index and argument, pulse its lane_grant bit, and go to ISSUE.
  - ISSUE: hold until core_ready. On the core_ready cycle, pulse core_start and go to WAIT.
  - WAIT: on core_done, capture core_result and go to WRITE.
  - WRITE: write the result into back[lane], set rr_ptr = lane+1 (wrapping), and go to IDLE.
- Latency: a request seen in IDLE produces the grant in that cycle. Earliest core_start is the next cycle. Back-buffer update follows core_done by 1 cycle. Minimum spacing between grants is 4 cycles.
- core_lane and core_arg are registered at grant and hold until the next grant. Arguments changing after grant do not affect the in-flight job.
- Fairness: a lane that is continuously requesting is granted at least once every NUM_LANES jobs.
- Frame swap: when vsync_prev==0 and vsync==1, front <= back and frame_swap pulses in that same cycle. This is independent of FSM state.
- Same-cycle swap and WRITE: the swap copies the pre-write back buffer. The new result lands in the back buffer and appears in the front buffer at the next frame.
- Results are stored unmodified (no saturation or scaling). Lanes with no completed job keep their previous back value.

Optional Feature:
GPU_SCHED_TIMEOUT_EN
- Defined: a counter runs in WAIT. If it reaches TIMEOUT with no core_done, back[lane] is written with all-ones and the FSM goes to IDLE, advancing rr_ptr as in WRITE. A done pulse at exactly the TIMEOUT cycle wins. An extra output timeout_err pulses for one cycle on abort.
- Undefined: WAIT has no limit, and the counter and timeout_err are not present.

Decomposition:
- Package gpu_pkg: sched_state_e enum (IDLE, ISSUE, WAIT, WRITE), default NUM_LANES and DATA_W constants, and lane_idx_t typedef.
- One sub-module, rr_arbiter: combinational round-robin first-requester-from-pointer select. Outputs a one-hot grant and a binary index.

Test Plan:
- Reset, then lane_req=4'b1111 with args 10,20,30,40 and a core model that returns arg+1 after 3 cycles → grants in lane order 0,1,2,3. After the next vsync rise, display_data = {41,31,21,11}.
- Only lane 2 requesting continuously → every grant goes to lane 2, and consecutive grants are exactly 4 cycles apart when the core returns done 1 cycle after start.
- core_ready held low for 10 cycles in ISSUE → core_start stays low, busy stays high. core_start pulses on the first cycle core_ready=1.
- vsync rises on the same cycle as WRITE for lane 1 with result 0x55 → front lane 1 keeps its old value and back lane 1 becomes 0x55. After the next vsync rise, front lane 1 = 0x55.
- rst pulsed during WAIT, then a stray core_done → FSM in IDLE, buffers at 0, no write occurs.
- With GPU_SCHED_TIMEOUT_EN and TIMEOUT=63, core_done withheld → at the 63rd WAIT cycle timeout_err pulses and back[lane]=0xFF. Done arriving on cycle 63 instead stores the real result.
